// File: rtl/param_cpu_if.sv
// Bus between param_cpu and its program/data memory environment.
// The core drives the master side; memories and stimulus use the slave side.
interface param_cpu_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] pc;
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              mem_read;
    logic              mem_write;
    logic              mem_ready;
    logic              zero_flag;
    logic              carry_flag;
    logic              halted;

    modport master (
        output pc, mem_addr, data_out, mem_read, mem_write,
               zero_flag, carry_flag, halted,
        input  instruction, data_in, mem_ready
    );

    modport slave (
        input  pc, mem_addr, data_out, mem_read, mem_write,
               zero_flag, carry_flag, halted,
        output instruction, data_in, mem_ready
    );
endinterface

// File: rtl/param_cpu.sv
// Small parameterised accumulator-style CPU: FETCH/EXEC/MEM/HALT sequencer,
// register file, ALU with zero/carry flags and a ready-handshaked data port.
module param_cpu #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int REG_CNT = 4
) (
    input  logic          clk,
    input  logic          reset,
    param_cpu_if.master   bus
);
    localparam int RI_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    localparam logic [3:0] OP_LD   = 4'd1;
    localparam logic [3:0] OP_ST   = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_JZ   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_JC   = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];

    logic              wr_en;
    logic [RI_W-1:0]   wr_idx;
    logic [DATA_W-1:0] wr_data;

    logic [3:0]        op;
    logic [RI_W-1:0]   rd_idx;
    logic [RI_W-1:0]   rs_idx;
    logic [7:0]        imm;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] imm_data;

    // Register fields wider than the register file leave high IR bits idle.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q;

    assign op       = ir_q[15:12];
    assign rd_idx   = ir_q[8 +: RI_W];
    assign rs_idx   = ir_q[4 +: RI_W];
    assign imm      = ir_q[7:0];
    assign rd_val   = regs_q[rd_idx];
    assign rs_val   = regs_q[rs_idx];
    assign sum_ext  = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff_ext = {1'b0, rd_val} - {1'b0, rs_val};
    assign imm_addr = ADDR_W'(imm);
    assign imm_data = DATA_W'(imm);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_addr_d  = mem_addr_q;
        data_out_d  = data_out_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        halted_d    = halted_q;
        wr_en       = 1'b0;
        wr_idx      = rd_idx;
        wr_data     = '0;

        case (state_q)
            S_FETCH: begin
                ir_d    = bus.instruction;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_LD: begin
                        mem_addr_d = imm_addr;
                        mem_read_d = 1'b1;
                        state_d    = S_MEM;
                    end
                    OP_ST: begin
                        mem_addr_d  = imm_addr;
                        mem_write_d = 1'b1;
                        data_out_d  = rd_val;
                        state_d     = S_MEM;
                    end
                    OP_ADD: begin
                        wr_en   = 1'b1;
                        wr_data = sum_ext[DATA_W-1:0];
                        carry_d = sum_ext[DATA_W];
                    end
                    OP_SUB: begin
                        // The extra top bit of the widened difference is the borrow.
                        wr_en   = 1'b1;
                        wr_data = diff_ext[DATA_W-1:0];
                        carry_d = diff_ext[DATA_W];
                    end
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = imm_data;
                    end
                    OP_AND: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val & rs_val;
                    end
                    OP_OR: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val | rs_val;
                    end
                    OP_XOR: begin
                        wr_en   = 1'b1;
                        wr_data = rd_val ^ rs_val;
                    end
                    OP_JMP: pc_d = imm_addr;
                    OP_JZ:  if (zero_q)  pc_d = imm_addr;
                    OP_JC:  if (carry_q) pc_d = imm_addr;
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                if (bus.mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = S_FETCH;
                    if (mem_read_q) begin
                        wr_en   = 1'b1;
                        wr_data = bus.data_in;
                    end
                end
            end

            default: ;
        endcase

        // Every register write (ALU, LDI, LD) refreshes the zero flag.
        if (wr_en) begin
            zero_d = (wr_data == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            mem_addr_q  <= '0;
            data_out_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            halted_q    <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_addr_q  <= mem_addr_d;
            data_out_q  <= data_out_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            halted_q    <= halted_d;
            if (wr_en) begin
                regs_q[wr_idx] <= wr_data;
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.data_out   = data_out_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.zero_flag  = zero_q;
    assign bus.carry_flag = carry_q;
    assign bus.halted     = halted_q;

    a_no_dual_strobe: assert property (@(posedge clk) disable iff (reset)
        !(mem_read_q && mem_write_q));

endmodule
